// File: rtl/bcd_mod_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bcd_mod_counter
//
// Two-digit BCD counter with a parametrised modulus (2..100). It counts up or
// down, takes a synchronous parallel load that is checked for validity, and
// raises a combinational terminal count so that stages can be cascaded by
// wiring one stage's TC into the next stage's EN. Typical use is the seconds
// and minutes (MODULUS=60) and hours (MODULUS=24) stages of a clock/alarm
// datapath.
//
// Parameters
//   MODULUS  count range is 0..MODULUS-1, legal 2..100
//
// Ports
//   CP       in   clock, all state changes on the rising edge
//   nCR      in   asynchronous active-low reset (count 00, LoadErr 0)
//   EN       in   count enable, one step per CP edge
//   Load     in   synchronous parallel load, priority over EN
//   Up       in   direction, 1 = increment, 0 = decrement
//   Din_H    in   [3:0] BCD tens digit to load
//   Din_L    in   [3:0] BCD units digit to load
//   Cnt_H    out  [3:0] registered BCD tens digit
//   Cnt_L    out  [3:0] registered BCD units digit
//   TC       out  terminal count, combinational, for cascading
//   LoadErr  out  registered one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module bcd_mod_counter #(
    parameter int MODULUS = 60
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic       Load,
    input  logic       Up,
    input  logic [3:0] Din_H,
    input  logic [3:0] Din_L,
    output logic [3:0] Cnt_H,
    output logic [3:0] Cnt_L,
    output logic       TC,
    output logic       LoadErr
);

    generate
        if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
            $error("bcd_mod_counter: MODULUS must be in 2..100");
        end
    endgenerate

    // Digits of the largest legal value, MODULUS-1.
    localparam logic [3:0] TOP_H = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] TOP_L = 4'((MODULUS - 1) % 10);

    logic [3:0] cnt_h_q, cnt_h_d;
    logic [3:0] cnt_l_q, cnt_l_d;
    logic       load_err_q, load_err_d;

    logic       at_top;
    logic       at_zero;
    logic       din_bcd_ok;
    logic       din_in_range;
    logic       din_ok;

    assign at_top  = (cnt_h_q == TOP_H) && (cnt_l_q == TOP_L);
    assign at_zero = (cnt_h_q == 4'd0) && (cnt_l_q == 4'd0);

    // With both digits valid BCD, 10*H+L < MODULUS is the same as the
    // digit-wise (lexicographic) compare H:L <= TOP_H:TOP_L, which avoids a
    // multiplier.
    assign din_bcd_ok   = (Din_H <= 4'd9) && (Din_L <= 4'd9);
    assign din_in_range = (Din_H < TOP_H) || ((Din_H == TOP_H) && (Din_L <= TOP_L));
    assign din_ok       = din_bcd_ok && din_in_range;

    always_comb begin
        cnt_h_d    = cnt_h_q;
        cnt_l_d    = cnt_l_q;
        load_err_d = 1'b0;
        if (Load) begin
            if (din_ok) begin
                cnt_h_d = Din_H;
                cnt_l_d = Din_L;
            end else begin
                // A rejected load still clears the count so the stage never
                // sits on a stale value the user thought was replaced.
                cnt_h_d    = 4'd0;
                cnt_l_d    = 4'd0;
                load_err_d = 1'b1;
            end
        end else if (EN) begin
            if (Up) begin
                if (at_top) begin
                    cnt_h_d = 4'd0;
                    cnt_l_d = 4'd0;
                end else if (cnt_l_q == 4'd9) begin
                    cnt_l_d = 4'd0;
                    cnt_h_d = cnt_h_q + 4'd1;
                end else begin
                    cnt_l_d = cnt_l_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    cnt_h_d = TOP_H;
                    cnt_l_d = TOP_L;
                end else if (cnt_l_q == 4'd0) begin
                    cnt_l_d = 4'd9;
                    cnt_h_d = cnt_h_q - 4'd1;
                end else begin
                    cnt_l_d = cnt_l_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            cnt_h_q    <= 4'd0;
            cnt_l_q    <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            cnt_h_q    <= cnt_h_d;
            cnt_l_q    <= cnt_l_d;
            load_err_q <= load_err_d;
        end
    end

    // Combinational so the next stage advances on the same edge this one wraps.
    assign TC = EN && !Load && (Up ? at_top : at_zero);

    assign Cnt_H   = cnt_h_q;
    assign Cnt_L   = cnt_l_q;
    assign LoadErr = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
`timescale 1ns/1ps
module tb_bcd_mod_counter;

    logic       cp;
    logic       ncr;
    logic       en;
    logic       load;
    logic       up;
    logic [3:0] din_h;
    logic [3:0] din_l;

    logic [3:0] cnt_h [4];
    logic [3:0] cnt_l [4];
    logic       tc    [4];
    logic       lerr  [4];

    // cascade: minutes (mod 60) feeds hours (mod 24)
    logic       c_en;
    logic       c_load;
    logic [3:0] c_min_dh, c_min_dl, c_hr_dh, c_hr_dl;
    logic [3:0] c_min_h, c_min_l, c_hr_h, c_hr_l;
    logic       c_min_tc, c_hr_tc, c_min_err, c_hr_err;

    int checks = 0;
    int errors = 0;

    int mods [4] = '{60, 24, 7, 100};
    int mval [4];
    int merr [4];

    bcd_mod_counter #(.MODULUS(60)) u_m60 (
        .CP(cp), .nCR(ncr), .EN(en), .Load(load), .Up(up), .Din_H(din_h), .Din_L(din_l),
        .Cnt_H(cnt_h[0]), .Cnt_L(cnt_l[0]), .TC(tc[0]), .LoadErr(lerr[0]));
    bcd_mod_counter #(.MODULUS(24)) u_m24 (
        .CP(cp), .nCR(ncr), .EN(en), .Load(load), .Up(up), .Din_H(din_h), .Din_L(din_l),
        .Cnt_H(cnt_h[1]), .Cnt_L(cnt_l[1]), .TC(tc[1]), .LoadErr(lerr[1]));
    bcd_mod_counter #(.MODULUS(7)) u_m7 (
        .CP(cp), .nCR(ncr), .EN(en), .Load(load), .Up(up), .Din_H(din_h), .Din_L(din_l),
        .Cnt_H(cnt_h[2]), .Cnt_L(cnt_l[2]), .TC(tc[2]), .LoadErr(lerr[2]));
    bcd_mod_counter #(.MODULUS(100)) u_m100 (
        .CP(cp), .nCR(ncr), .EN(en), .Load(load), .Up(up), .Din_H(din_h), .Din_L(din_l),
        .Cnt_H(cnt_h[3]), .Cnt_L(cnt_l[3]), .TC(tc[3]), .LoadErr(lerr[3]));

    bcd_mod_counter #(.MODULUS(60)) u_min (
        .CP(cp), .nCR(ncr), .EN(c_en), .Load(c_load), .Up(1'b1), .Din_H(c_min_dh), .Din_L(c_min_dl),
        .Cnt_H(c_min_h), .Cnt_L(c_min_l), .TC(c_min_tc), .LoadErr(c_min_err));
    bcd_mod_counter #(.MODULUS(24)) u_hr (
        .CP(cp), .nCR(ncr), .EN(c_min_tc), .Load(c_load), .Up(1'b1), .Din_H(c_hr_dh), .Din_L(c_hr_dl),
        .Cnt_H(c_hr_h), .Cnt_L(c_hr_l), .TC(c_hr_tc), .LoadErr(c_hr_err));

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit din_valid(int m, int h, int l);
        return (h <= 9) && (l <= 9) && ((10 * h + l) < m);
    endfunction

    function automatic logic [7:0] bcd(int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_m%0d_cnt", tag, mods[i]), {24'd0, cnt_h[i], cnt_l[i]}, {24'd0, bcd(mval[i])});
            chk($sformatf("%s_m%0d_lerr", tag, mods[i]), {31'd0, lerr[i]}, merr[i]);
        end
    endtask

    // One clock step: drive, check TC mid-cycle, clock, update model, check state.
    task automatic step(input string tag, input bit e, input bit ld, input bit u, input int dh, input int dl);
        bit exp_tc;
        en = e; load = ld; up = u; din_h = 4'(dh); din_l = 4'(dl);
        @(negedge cp);
        for (int i = 0; i < 4; i++) begin
            exp_tc = e && !ld && (u ? (mval[i] == mods[i] - 1) : (mval[i] == 0));
            chk($sformatf("%s_m%0d_tc", tag, mods[i]), {31'd0, tc[i]}, {31'd0, exp_tc});
        end
        @(posedge cp);
        for (int i = 0; i < 4; i++) begin
            if (ld) begin
                if (din_valid(mods[i], dh, dl)) begin
                    mval[i] = 10 * dh + dl;
                    merr[i] = 0;
                end else begin
                    mval[i] = 0;
                    merr[i] = 1;
                end
            end else begin
                merr[i] = 0;
                if (e) mval[i] = u ? (mval[i] + 1) % mods[i] : (mval[i] + mods[i] - 1) % mods[i];
            end
        end
        #1;
        check_state(tag);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mval[i] = 0;
            merr[i] = 0;
        end
    endtask

    initial begin
        int total;
        int bad_bcd;
        int dh, dl;
        ncr = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1; din_h = '0; din_l = '0;
        c_en = 1'b0; c_load = 1'b0;
        c_min_dh = '0; c_min_dl = '0; c_hr_dh = '0; c_hr_dl = '0;
        model_reset();

        #12;
        check_state("reset");
        chk("reset_min_tc", {31'd0, c_min_tc}, 32'd0);
        ncr = 1'b1;

        // async reset mid-count
        step("load37", 1'b0, 1'b1, 1'b1, 3, 7);
        ncr = 1'b0;
        #2;
        model_reset();
        check_state("async_rst");
        ncr = 1'b1;
        #1;
        step("post_rst", 1'b1, 1'b0, 1'b1, 0, 0);

        // up wrap; load with EN/Up active must give loaded value
        step("load58", 1'b1, 1'b1, 1'b1, 5, 8);
        step("up59", 1'b1, 1'b0, 1'b1, 0, 0);
        step("upwrap", 1'b1, 1'b0, 1'b1, 0, 0);
        step("up01", 1'b1, 1'b0, 1'b1, 0, 0);
        step("load09", 1'b0, 1'b1, 1'b1, 0, 9);
        step("carry", 1'b1, 1'b0, 1'b1, 0, 0);

        // down wrap and borrow
        step("load01", 1'b1, 1'b1, 1'b0, 0, 1);
        step("dn00", 1'b1, 1'b0, 1'b0, 0, 0);
        step("dnwrap", 1'b1, 1'b0, 1'b0, 0, 0);
        step("dn22", 1'b1, 1'b0, 1'b0, 0, 0);
        step("load20", 1'b0, 1'b1, 1'b0, 2, 0);
        step("borrow", 1'b1, 1'b0, 1'b0, 0, 0);

        // load validity
        step("load23", 1'b0, 1'b1, 1'b1, 2, 3);
        step("load24", 1'b0, 1'b1, 1'b1, 2, 4);
        step("err_clear", 1'b0, 1'b0, 1'b1, 0, 0);
        step("loadA", 1'b0, 1'b1, 1'b1, 0, 10);
        step("loadF0", 1'b1, 1'b1, 1'b0, 15, 0);
        step("load99", 1'b1, 1'b1, 1'b1, 9, 9);

        // hold
        step("load45", 1'b0, 1'b1, 1'b1, 4, 5);
        for (int k = 0; k < 5; k++) step($sformatf("hold%0d", k), 1'b0, 1'b0, k[0], 0, 0);
        step("resume", 1'b1, 1'b0, 1'b1, 0, 0);

        // randomized
        for (int k = 0; k < 400; k++) begin
            dh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            step($sformatf("rnd%0d", k), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1, dh, dl);
        end
        en = 1'b0; load = 1'b0;

        // cascade: 23:59 -> 00:00 on one edge
        c_load = 1'b1; c_hr_dh = 4'd2; c_hr_dl = 4'd3; c_min_dh = 4'd5; c_min_dl = 4'd9;
        @(posedge cp); #1;
        c_load = 1'b0;
        chk("casc_load", {24'd0, c_hr_h, c_hr_l}, 32'h23);
        chk("casc_load_min", {24'd0, c_min_h, c_min_l}, 32'h59);
        c_en = 1'b1;
        @(negedge cp);
        chk("casc_min_tc", {31'd0, c_min_tc}, 32'd1);
        chk("casc_hr_tc", {31'd0, c_hr_tc}, 32'd1);
        @(posedge cp); #1;
        chk("casc_wrap", {16'd0, c_hr_h, c_hr_l, c_min_h, c_min_l}, 32'h0000);

        // full day
        total = 0;
        bad_bcd = 0;
        for (int k = 0; k < 1440; k++) begin
            @(posedge cp); #1;
            total = (total + 1) % 1440;
            if (c_hr_h > 4'd9 || c_hr_l > 4'd9 || c_min_h > 4'd9 || c_min_l > 4'd9) bad_bcd++;
            chk($sformatf("casc_t%0d", k), {16'd0, c_hr_h, c_hr_l, c_min_h, c_min_l},
                {16'd0, bcd(total / 60), bcd(total % 60)});
        end
        c_en = 1'b0;
        chk("casc_day_end", {16'd0, c_hr_h, c_hr_l, c_min_h, c_min_l}, 32'h0000);
        chk("casc_bad_bcd", bad_bcd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised two-digit BCD counter with modulus MODULUS (2..100), generalising the fixed mod-6 digit counter.
- Adds up/down counting, synchronous parallel load with validity checking, and a terminal-count output for cascading.
- Used as the seconds/minutes (mod 60) and hours (mod 24) stages of the clock and alarm-set datapath.
- Stages chain by feeding one stage's TC into the next stage's EN.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1. Legal 2..100; elaboration fails outside this range.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- nCR  input  1  asynchronous active-low reset.
- EN  input  1  count enable; high = advance one step per CP edge.
- Load  input  1  synchronous parallel load; has priority over EN.
- Up  input  1  direction; 1 = increment, 0 = decrement.
- Din_H  input  4  BCD tens digit to load.
- Din_L  input  4  BCD units digit to load.
- Cnt_H  output  4  BCD tens digit of count (registered).
- Cnt_L  output  4  BCD units digit of count (registered).
- TC  output  1  terminal count (combinational).
- LoadErr  output  1  one-cycle registered pulse: last load was rejected.

Behaviour:
- Definitions:
  - TOP_H = (MODULUS-1)/10.
  - TOP_L = (MODULUS-1)%10.
  - Value V = 10*Cnt_H + Cnt_L.
  - Both digits are always valid BCD (0..9), and V < MODULUS at all times.
- Reset:
  - nCR low forces Cnt_H=0, Cnt_L=0, LoadErr=0 immediately, independent of CP.
  - Reset dominates everything and may assert mid-count or mid-load.
  - After nCR rises, the first CP edge is evaluated normally.
- Per-edge priority (nCR high): Load > EN > hold.
- Load=1:
  - Valid when Din_H<=9, Din_L<=9 and 10*Din_H+Din_L < MODULUS. Then the counter takes Din_H/Din_L and LoadErr=0 next cycle.
  - Otherwise the counter takes 00 and LoadErr=1 for exactly the next cycle.
  - EN and Up are ignored on a load cycle.
- Load=0, EN=1, Up=1 (increment):
  - If V == MODULUS-1, wrap to 00.
  - Else if Cnt_L==9, Cnt_L becomes 0 and Cnt_H increments.
  - Else Cnt_L increments.
- Load=0, EN=1, Up=0 (decrement):
  - If V == 0, wrap to TOP_H/TOP_L.
  - Else if Cnt_L==0, Cnt_L becomes 9 and Cnt_H decrements.
  - Else Cnt_L decrements.
- Load=0, EN=0: hold. LoadErr returns to 0 on every non-load edge.
- TC = EN & ~Load & ((Up & V==MODULUS-1) | (~Up & V==0)).
  - Purely combinational, so a downstream stage advances on the same edge this stage wraps.
  - TC must not depend on LoadErr.
- Latency:
  - Count and load results are visible one CP edge after the sampled inputs.
  - TC follows inputs and state within the same cycle.
- MODULUS=100: TOP=99, full two-digit range.
- MODULUS<10: Cnt_H is constantly 0.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset/async (MODULUS=60):
  - Run to 37, pulse nCR low between edges; outputs go to 00/LoadErr=0 before the next CP.
  - Release nCR; the next EN edge gives 01.
- Up wrap (MODULUS=60):
  - Load 58, EN=1, Up=1; sequence 58, 59, 00, 01.
  - TC=1 only while V=59.
  - Units carry 09 -> 10 checked.
- Down wrap (MODULUS=24):
  - Load 01, EN=1, Up=0; sequence 01, 00, 23, 22.
  - TC=1 only while V=00.
  - Borrow 20 -> 19 checked.
- Load checks (MODULUS=24):
  - Load 23 gives 23, LoadErr=0.
  - Load 24 gives 00 with a single-cycle LoadErr=1.
  - Load Din_L=4'hA gives 00 with LoadErr=1.
  - Load with EN=1 and Up=1 gives the loaded value, not value+1, and TC=0 that cycle.
- Hold/enable: at 45, EN=0 for 5 edges; count stays 45 and TC=0. EN=1 resumes at 46.
- Cascade: mod-60 units stage TC drives a mod-24 stage EN.
  - From 23:59 with EN=1, one edge gives 00:00.
  - Full 1440-edge run returns to 00:00 with no invalid BCD observed.
